// File: rtl/iob_cache_axi_mem_responder.sv
// AXI4 slave backed by an internal word array: independent write and read FSMs,
// one outstanding transaction per path, INCR full-width bursts only.
module iob_cache_axi_mem_responder #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [AXI_ID_W-1:0]     axi_awid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic [2:0]              axi_awsize_i,
  input  logic [1:0]              axi_awburst_i,
  input  logic                    axi_awlock_i,
  input  logic [3:0]              axi_awcache_i,
  input  logic [2:0]              axi_awprot_i,
  input  logic [3:0]              axi_awqos_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  output logic [AXI_ID_W-1:0]     axi_bid_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  input  logic [AXI_ID_W-1:0]     axi_arid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic [2:0]              axi_arsize_i,
  input  logic [1:0]              axi_arburst_i,
  input  logic                    axi_arlock_i,
  input  logic [3:0]              axi_arcache_i,
  input  logic [2:0]              axi_arprot_i,
  input  logic [3:0]              axi_arqos_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  output logic [AXI_ID_W-1:0]     axi_rid_o,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i
);

  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int DEPTH  = 1 << MEM_ADDR_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_BURST} rstate_t;

  logic [AXI_DATA_W-1:0] mem_q [DEPTH];

  wstate_t               wstate_q;
  logic                  awready_q, wready_q, bvalid_q, werr_q;
  logic [AXI_ID_W-1:0]   bid_q;
  logic [1:0]            bresp_q;
  logic [MEM_ADDR_W-1:0] widx_q, widx_d;
  logic [AXI_LEN_W-1:0]  wlen_q, wcnt_q, wcnt_d;
  logic                  w_hs;

  rstate_t               rstate_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [AXI_ID_W-1:0]   rid_q;
  logic [AXI_DATA_W-1:0] rdata_q;
  logic [MEM_ADDR_W-1:0] ridx_q, ridx_d, ar_idx;
  logic [AXI_LEN_W-1:0]  rlen_q, rcnt_q, rcnt_d;

  logic unused_in;
  assign unused_in = ^{axi_awsize_i, axi_awburst_i, axi_awlock_i, axi_awcache_i,
                       axi_awprot_i, axi_awqos_i, axi_arsize_i, axi_arburst_i,
                       axi_arlock_i, axi_arcache_i, axi_arprot_i, axi_arqos_i,
                       axi_awaddr_i, axi_araddr_i};

  assign widx_d = widx_q + 1'b1;
  assign wcnt_d = wcnt_q + 1'b1;
  assign ridx_d = ridx_q + 1'b1;
  assign rcnt_d = rcnt_q + 1'b1;
  assign ar_idx = axi_araddr_i[OFF +: MEM_ADDR_W];
  // A beat arriving together with reset is dropped so an abandoned burst leaves no trace.
  assign w_hs   = wready_q & axi_wvalid_i & rst_n_i;

  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi_wstrb_i[b]) mem_q[widx_q][8*b +: 8] <= axi_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      werr_q    <= 1'b0;
      widx_q    <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: if (axi_awvalid_i) begin
          bid_q     <= axi_awid_i;
          widx_q    <= axi_awaddr_i[OFF +: MEM_ADDR_W];
          wlen_q    <= axi_awlen_i;
          wcnt_q    <= '0;
          werr_q    <= 1'b0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          wstate_q  <= W_DATA;
        end
        W_DATA: if (axi_wvalid_i) begin
          widx_q <= widx_d;
          wcnt_q <= wcnt_d;
          if (axi_wlast_i) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= (!werr_q && wcnt_q == wlen_q) ? 2'b00 : 2'b10;
            wstate_q <= W_RESP;
          end else if (wcnt_q == wlen_q) begin
            // Overrun past len: keep writing, but the burst can no longer end OKAY.
            werr_q <= 1'b1;
          end
        end
        W_RESP: if (axi_bready_i) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wstate_q  <= W_IDLE;
        end
        default: begin
          wstate_q  <= W_IDLE;
          awready_q <= 1'b1;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: if (axi_arvalid_i) begin
          rid_q     <= axi_arid_i;
          ridx_q    <= ar_idx;
          rlen_q    <= axi_arlen_i;
          rcnt_q    <= '0;
          rdata_q   <= mem_q[ar_idx];
          rlast_q   <= (axi_arlen_i == '0);
          rvalid_q  <= 1'b1;
          arready_q <= 1'b0;
          rstate_q  <= R_BURST;
        end
        R_BURST: if (axi_rready_i) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end else begin
            ridx_q  <= ridx_d;
            rcnt_q  <= rcnt_d;
            rdata_q <= mem_q[ridx_d];
            rlast_q <= (rcnt_d == rlen_q);
          end
        end
        default: begin
          rstate_q  <= R_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
        end
      endcase
    end
  end

  assign axi_awready_o = awready_q;
  assign axi_wready_o  = wready_q;
  assign axi_bvalid_o  = bvalid_q;
  assign axi_bid_o     = bid_q;
  assign axi_bresp_o   = bresp_q;
  assign axi_arready_o = arready_q;
  assign axi_rvalid_o  = rvalid_q;
  assign axi_rlast_o   = rlast_q;
  assign axi_rid_o     = rid_q;
  assign axi_rdata_o   = rdata_q;
  assign axi_rresp_o   = 2'b00;

endmodule

// File: tb/tb_iob_cache_axi_mem_responder.sv
// Randomized bench for iob_cache_axi_mem_responder against a word-array reference model.
module tb_iob_cache_axi_mem_responder;
  localparam int ID_W = 1, ADDR_W = 24, DATA_W = 32, LEN_W = 8, MEM_W = 10;
  localparam int DEPTH = 1 << MEM_W;
  localparam int BUDGET = 100;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ID_W-1:0]   awid, arid, bid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [LEN_W-1:0]  awlen, arlen;
  logic [2:0]        awsize, arsize, awprot, arprot;
  logic [1:0]        awburst, arburst, bresp, rresp;
  logic              awlock, arlock;
  logic [3:0]        awcache, arcache, awqos, arqos, wstrb;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;

  iob_cache_axi_mem_responder dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
    .axi_awburst_i(awburst), .axi_awlock_i(awlock), .axi_awcache_i(awcache),
    .axi_awprot_i(awprot), .axi_awqos_i(awqos), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
    .axi_wready_o(wready), .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid),
    .axi_bready_i(bready),
    .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
    .axi_arburst_i(arburst), .axi_arlock_i(arlock), .axi_arcache_i(arcache),
    .axi_arprot_i(arprot), .axi_arqos_i(arqos), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready)
  );

  int n_cmp = 0, n_err = 0;
  logic [DATA_W-1:0] mm [DEPTH];
  logic [DATA_W-1:0] wq_d [$];
  logic [3:0]        wq_s [$];
  logic [DATA_W-1:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no handshake within %0d cycles", tag, BUDGET);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'(a[2 +: MEM_W]);
  endfunction

  task automatic axi_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input int len, input int nbeats);
    int t, idx;
    chk("wready_in_idle", wready, 1'b0);
    awid = id; awaddr = addr; awlen = LEN_W'(len); awvalid = 1'b1;
    awsize = 3'($urandom); awburst = 2'($urandom); awqos = 4'($urandom);
    t = 0;
    while (!awready && t < BUDGET) begin tick(); t++; end
    if (t >= BUDGET) timeout("aw_hs");
    tick();
    awvalid = 1'b0; awaddr = ADDR_W'($urandom);
    idx = idx_of(addr);
    for (int b = 0; b < nbeats; b++) begin
      wdata = wq_d[b]; wstrb = wq_s[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
      t = 0;
      while (!wready && t < BUDGET) begin tick(); t++; end
      if (t >= BUDGET) timeout("w_hs");
      tick();
      for (int k = 0; k < 4; k++) if (wq_s[b][k]) mm[idx][8*k +: 8] = wq_d[b][8*k +: 8];
      idx = (idx + 1) % DEPTH;
      wvalid = 1'b0; wlast = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    t = 0;
    while (!bvalid && t < BUDGET) begin tick(); t++; end
    if (t >= BUDGET) timeout("b_valid");
    chk("bid", bid, id);
    chk("bresp", bresp, (nbeats == len + 1) ? 2'b00 : 2'b10);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("b_hold_valid", bvalid, 1'b1);
      chk("b_hold_resp", bresp, (nbeats == len + 1) ? 2'b00 : 2'b10);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("awready_after_b", awready, 1'b1);
  endtask

  task automatic axi_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input int len, input int stall_beat, input int stall_cyc);
    int t, idx, ns;
    logic [DATA_W-1:0] exp;
    arid = id; araddr = addr; arlen = LEN_W'(len); arvalid = 1'b1;
    arsize = 3'($urandom); arburst = 2'($urandom); arqos = 4'($urandom);
    t = 0;
    while (!arready && t < BUDGET) begin tick(); t++; end
    if (t >= BUDGET) timeout("ar_hs");
    tick();
    arvalid = 1'b0; araddr = ADDR_W'($urandom);
    chk("r_first_latency", rvalid, 1'b1);
    idx = idx_of(addr);
    for (int b = 0; b <= len; b++) begin
      t = 0;
      while (!rvalid && t < BUDGET) begin tick(); t++; end
      if (t >= BUDGET) timeout("r_valid");
      exp = mm[idx];
      chk("rdata", rdata, exp);
      chk("rid", rid, id);
      chk("rresp", rresp, 2'b00);
      chk("rlast", rlast, b == len);
      last_rdata = rdata;
      ns = (b == stall_beat) ? stall_cyc : $urandom_range(0, 1);
      for (int s = 0; s < ns; s++) begin
        tick();
        chk("r_stall_valid", rvalid, 1'b1);
        chk("r_stall_data", rdata, exp);
        chk("r_stall_last", rlast, b == len);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      idx = (idx + 1) % DEPTH;
    end
    chk("rvalid_after_last", rvalid, 1'b0);
  endtask

  task automatic fill(input int n, input logic [3:0] strb);
    wq_d.delete(); wq_s.delete();
    for (int i = 0; i < n; i++) begin
      wq_d.push_back(DATA_W'($urandom));
      wq_s.push_back(strb == 4'h0 ? 4'($urandom) : strb);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, awready, 1'b1);
    chk({tag, "_arready"}, arready, 1'b1);
    chk({tag, "_wready"}, wready, 1'b0);
    chk({tag, "_bvalid"}, bvalid, 1'b0);
    chk({tag, "_rvalid"}, rvalid, 1'b0);
    chk({tag, "_rlast"}, rlast, 1'b0);
    chk({tag, "_bresp"}, bresp, 2'b00);
    chk({tag, "_rresp"}, rresp, 2'b00);
    chk({tag, "_bid"}, bid, 1'b0);
    chk({tag, "_rid"}, rid, 1'b0);
    chk({tag, "_rdata"}, rdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, nb, old_idx;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] old_w, new_w;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = 2'b01; awlock = 1'b0;
    awcache = '0; awprot = '0; awqos = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = 2'b01; arlock = 1'b0;
    arcache = '0; arprot = '0; arqos = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    last_rdata = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 4; k++) begin
      fill(256, 4'hF);
      axi_write(1'b0, ADDR_W'(k * 1024), 255, 256);
    end

    fill(4, 4'hF);
    axi_write(1'b0, 24'h000040, 3, 4);
    axi_read(1'b1, 24'h000040, 3, -1, 0);

    wq_d = '{32'hAABBCCDD}; wq_s = '{4'hF};
    axi_write(1'b0, 24'h000080, 0, 1);
    wq_d = '{32'h11223344}; wq_s = '{4'b0101};
    axi_write(1'b1, 24'h000080, 0, 1);
    axi_read(1'b0, 24'h000080, 0, -1, 0);
    chk("strb_merge", last_rdata, 32'hAA22CC44);

    fill(2, 4'hF);
    axi_write(1'b1, 24'h000100, 3, 2);
    fill(5, 4'h0);
    axi_write(1'b0, 24'h000140, 1, 5);

    axi_read(1'b1, 24'h000100, 7, 3, 5);

    fill(2, 4'hF);
    axi_write(1'b1, 24'hF03FFC, 1, 2);
    axi_read(1'b0, 24'h003FFC, 1, -1, 0);
    chk("wrap_to_zero", last_rdata, mm[0]);

    // Same-word read and write completing on the same edge.
    a = 24'h000200; old_idx = idx_of(a); old_w = mm[old_idx]; new_w = ~old_w;
    awid = 1'b0; awaddr = a; awlen = '0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wdata = new_w; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 1'b1; araddr = a; arlen = '0; arvalid = 1'b1;
    chk("same_cycle_wready", wready, 1'b1);
    chk("same_cycle_arready", arready, 1'b1);
    tick();
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    chk("same_cycle_rdata_old", rdata, old_w);
    chk("same_cycle_rlast", rlast, 1'b1);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0;
    chk("same_cycle_bresp", bresp, 2'b00);
    tick();
    bready = 1'b0;
    mm[old_idx] = new_w;
    axi_read(1'b0, a, 0, -1, 0);

    // Reset during beat 2 of an 8-beat read.
    arid = 1'b1; araddr = 24'h000300; arlen = 8'd7; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("abort_beat2_valid", rvalid, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_outputs("abort");
    axi_read(1'b0, 24'h000300, 7, -1, 0);

    for (int i = 0; i < 40; i++) begin
      a = ADDR_W'($urandom);
      len = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0) begin
        nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len + 3) : len + 1;
        fill(nb, 4'h0);
        axi_write(ID_W'($urandom), a, len, nb);
      end else begin
        axi_read(ID_W'($urandom), a, len, -1, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
